// File: rtl/mult_share_arb_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mult_share_arb_if : requester and result handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic [IDW-1:0]    res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// mult_share_arb : round-robin sharing of one 8x8 array multiplier
// Rev 1.0
// ------------------------------------------------------------------
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  mult_share_arb_if.slave bus,
  output logic            busy,
  output logic [15:0]     ops_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [7:0]      a_arr [NREQ];
  logic [7:0]      b_arr [NREQ];
  logic [NREQ-1:0] pick_oh;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [IDW:0]    slot;
  logic [IDW:0]    ptr_inc;
  logic [IDW-1:0]  ptr_next;
  logic [15:0]     product;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[8*i +: 8];
    assign b_arr[i] = bus.req_b[8*i +: 8];
  end

  // Rotating priority search starting at rr_ptr; first valid hit wins.
  always_comb begin
    pick_oh  = '0;
    pick_id  = '0;
    pick_any = 1'b0;
    slot     = '0;
    for (int k = 0; k < NREQ; k++) begin
      slot = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (slot >= (IDW+1)'(NREQ)) begin
        slot = slot - (IDW+1)'(NREQ);
      end
      if (!pick_any && bus.req_valid[slot[IDW-1:0]]) begin
        pick_any                = 1'b1;
        pick_id                 = slot[IDW-1:0];
        pick_oh[slot[IDW-1:0]]  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_inc  = {1'b0, pick_id} + (IDW+1)'(1);
    ptr_next = (ptr_inc == (IDW+1)'(NREQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  assign bus.req_ready = (state == IDLE && !rst) ? pick_oh : '0;

  // Shift-and-add array: one partial-product row per bit of op_b.
  always_comb begin
    product = '0;
    for (int i = 0; i < 8; i++) begin
      if (op_b[i]) begin
        product = product + ({8'h00, op_a} << i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
      bus.res_valid <= 1'b0;
      ops_count     <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            op_a       <= a_arr[pick_id];
            op_b       <= b_arr[pick_id];
            bus.res_id <= pick_id;
            rr_ptr     <= ptr_next;
            state      <= MUL;
            busy       <= 1'b1;
          end
        end
        MUL: begin
          bus.res_data  <= product;
          bus.res_valid <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            ops_count     <= ops_count + 16'd1;
            state         <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mult_share_arb : directed vectors and corner sequences
// Rev 1.0
// ------------------------------------------------------------------
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] ops_count;

  mult_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .ops_count (ops_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (bus.req_ready == '0 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*id +: 8] = a;
    bus.req_b[8*id +: 8] = b;
    bus.req_valid[id]    = 1'b1;
  endtask

  // One isolated operation from requester id, starting and ending in IDLE.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    bus.req_valid = '0;
    set_req(id, a, b);
    #1;
    wait_grant(n);
    chk("grant", 32'(bus.req_ready), 32'(1 << id));
    step();
    bus.req_valid[id] = 1'b0;
    chk("mul_no_valid", 32'(bus.res_valid), 32'd0);
    chk("mul_busy", 32'(busy), 32'd1);
    step();
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    chk("res_data", 32'(bus.res_data), 32'(exp));
    chk("res_id", 32'(bus.res_id), 32'(id));
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Requester-side rule: operands stay put while a request waits for its grant.
  logic [NREQ-1:0]   pv, pr;
  logic [8*NREQ-1:0] pa, pb;
  logic              pvld = 1'b0;
  always @(posedge clk) begin
    if (!rst && pvld) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pv[i] && !pr[i] && bus.req_valid[i]) begin
          assert (bus.req_a[8*i +: 8] == pa[8*i +: 8] && bus.req_b[8*i +: 8] == pb[8*i +: 8])
            else $error("operand hold violated on requester %0d", i);
        end
      end
    end
    pv   <= bus.req_valid;
    pr   <= bus.req_ready;
    pa   <= bus.req_a;
    pb   <= bus.req_b;
    pvld <= !rst;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int e;
    logic [7:0] ra, rb;
    int rid;

    vecs[0] = '{2, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{0, 8'h00, 8'hAB, 16'h0000};
    vecs[2] = '{1, 8'h01, 8'h80, 16'h0080};
    vecs[3] = '{3, 8'h80, 8'h02, 16'h0100};
    vecs[4] = '{2, 8'h0F, 8'h0F, 16'h00E1};
    vecs[5] = '{1, 8'hFF, 8'h01, 16'h00FF};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    step();
    bus.req_valid = 4'b0001;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    step();

    // Directed vector table
    for (int k = 0; k < 6; k++) begin
      run_op(vecs[k].id, vecs[k].a, vecs[k].b, vecs[k].exp);
      chk("vec_ops_count", 32'(ops_count), 32'(k + 1));
    end

    // Round-robin with all requesters held valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 8'(8'h20 + i));
    #1;
    for (int k = 0; k < 6; k++) begin
      wait_grant(n);
      e = k % NREQ;
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << e));
      if (k > 0) chk("rr_interval", 32'(n), 32'd1);
      step();
      step();
      chk("rr_data", 32'(bus.res_data), 32'((16 + e) * (32 + e)));
      chk("rr_id", 32'(bus.res_id), 32'(e));
    end
    bus.req_valid = '0;
    step();

    // Backpressure with a second requester waiting
    do_reset();
    bus.res_ready = 1'b0;
    set_req(1, 8'h12, 8'h34);
    #1;
    wait_grant(n);
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    set_req(3, 8'h05, 8'h07);
    step();
    chk("bp_valid", 32'(bus.res_valid), 32'd1);
    chk("bp_data", 32'(bus.res_data), 32'h03A8);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.res_data), 32'h03A8);
      chk("bp_hold_id", 32'(bus.res_id), 32'd1);
      chk("bp_no_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_count_hold", 32'(ops_count), 32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    chk("bp_next_grant", 32'(bus.req_ready), 32'b1000);
    chk("bp_count", 32'(ops_count), 32'd1);
    chk("bp_valid_drop", 32'(bus.res_valid), 32'd0);
    step();
    bus.req_valid = '0;
    step();
    chk("bp2_data", 32'(bus.res_data), 32'h0023);
    chk("bp2_id", 32'(bus.res_id), 32'd3);
    step();

    // Random operations against a golden product
    for (int k = 0; k < 1000; k++) begin
      rid = $urandom_range(0, NREQ - 1);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run_op(rid, ra, rb, 16'(ra) * 16'(rb));
    end

    // Reset during MUL
    bus.req_valid = '0;
    set_req(2, 8'h33, 8'h44);
    #1;
    wait_grant(n);
    step();
    rst = 1'b1;
    #1;
    chk("rmul_valid", 32'(bus.res_valid), 32'd0);
    chk("rmul_count", 32'(ops_count), 32'd0);
    chk("rmul_ptr", 32'(dut.rr_ptr), 32'd0);
    chk("rmul_busy", 32'(busy), 32'd0);
    chk("rmul_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    bus.req_valid = '0;
    rst = 1'b0;
    set_req(1, 8'h03, 8'h05);
    set_req(3, 8'h09, 8'h09);
    #1;
    chk("rmul_first_grant", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = '0;
    step();
    chk("rmul_data", 32'(bus.res_data), 32'h000F);
    chk("rmul_id", 32'(bus.res_id), 32'd1);
    step();

    // Reset during DONE
    set_req(2, 8'h22, 8'h02);
    #1;
    wait_grant(n);
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    chk("rdone_valid", 32'(bus.res_valid), 32'd0);
    chk("rdone_count", 32'(ops_count), 32'd0);
    chk("rdone_ptr", 32'(dut.rr_ptr), 32'd0);
    step();
    rst = 1'b0;
    set_req(2, 8'h07, 8'h09);
    set_req(3, 8'h02, 8'h02);
    #1;
    chk("rdone_first_grant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = '0;
    step();
    chk("rdone_data", 32'(bus.res_data), 32'h003F);
    chk("rdone_id", 32'(bus.res_id), 32'd2);
    step();
    chk("rdone_count_after", 32'(ops_count), 32'd1);

    // Counter wrap
    force dut.ops_count = 16'hFFFF;
    step();
    release dut.ops_count;
    run_op(0, 8'h02, 8'h03, 16'h0006);
    chk("wrap_count", 32'(ops_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Shares one combinational 8x8 unsigned array multiplier between NREQ requesters.
- Round-robin arbitration, operand capture, and a registered product.
- Result is returned with the requester ID over a valid/ready output.
- Sits between the ALU-side requesters and the single multiplier instance. Only one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NREQ  per-requester request valid
- req_a  input  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  input  8*NREQ  operand B; same packing as req_a
- req_ready  output  NREQ  one-hot grant/accept; combinational from state, pointer and req_valid
- res_valid  output  1  result valid
- res_ready  input  1  downstream accepts result
- res_data  output  16  product A*B, unsigned
- res_id  output  IDW  index of the requester that issued the operation
- busy  output  1  high in any state other than IDLE
- ops_count  output  16  completed-operation counter, wraps at 16'hFFFF -> 0

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, op_a=0, op_b=0, res_data=0, res_id=0, res_valid=0, ops_count=0.
- States: IDLE, MUL, DONE.
- IDLE
  - req_ready has exactly one bit set: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... NREQ-1, 0, ... wrapping modulo NREQ.
  - req_ready = 0 if no request is valid.
  - On the edge with a grant: latch that requester's A, B and ID; set rr_ptr = (granted+1) mod NREQ; go to MUL.
- MUL
  - req_ready = 0.
  - Multiplier inputs are op_a/op_b.
  - On the edge: res_data <= product, res_valid <= 1; go to DONE.
- DONE
  - req_ready = 0.
  - res_valid, res_data and res_id are held stable until res_valid&res_ready.
  - On that handshake edge: res_valid <= 0, ops_count <= ops_count+1, go to IDLE.
  - No new grant is made in the same cycle as the handshake.
- Latency: acceptance edge E0; res_valid is high after E0+1. Minimum issue interval is 3 cycles (IDLE, MUL, DONE with res_ready=1).
- Round-robin: rr_ptr changes only on a grant. A requester that drops req_valid before grant is skipped with no penalty. Requesters must hold req_valid and operands stable until granted (requester-side rule; assertion in the bench).
- Width: res_data is the full 16-bit product, never truncated (0xFF*0xFF = 0xFE01).
- Simultaneous requests: only one grant per cycle. The others wait and are served in rotated order.
- res_ready while res_valid=0: ignored.
- rst asserted mid-operation:
  - immediate return to reset values;
  - the in-flight operation is discarded with no result and no count;
  - req_ready goes to 0 while rst is high.
- ops_count: increments only on the result handshake; FFFF+1 -> 0000.

Test Plan:
- Single op: only req 2 valid, A=0xFF, B=0xFF, res_ready=1.
  - Required: req_ready=4'b0100 for one cycle.
  - Required: one cycle later, res_valid=1, res_data=0xFE01, res_id=2, ops_count=1 after the handshake.
- Round-robin fairness: all 4 requesters held valid continuously, res_ready=1.
  - Required: grant order 0,1,2,3,0,1; one grant every 3 cycles; products match A*B per ID.
- Backpressure: res_ready=0 for 5 cycles after res_valid rises, A=0x12, B=0x34.
  - Required: res_data=0x03A8 and res_id held stable; no req_ready asserted.
  - Required: the next grant is on the cycle after the handshake.
- Corner operands: (0x00,0xAB), (0x01,0x80), (0x80,0x02).
  - Required: results 0x0000, 0x0080, 0x0100.
  - Random 1000 ops checked against a golden A*B.
- Reset mid-op: assert rst during MUL, then during DONE.
  - Required: res_valid=0 immediately, ops_count=0, rr_ptr=0.
  - Required: the first grant after release goes to the lowest valid index.
- Counter wrap: force ops_count to 0xFFFF via the bench, complete one op.
  - Required: ops_count=0x0000.
